// File: rtl/i2s_capture_ctrl.sv
// Capture session controller: enables the I2S mic, throws away its power-up samples,
// then forwards PCM samples through a single-entry valid/ready output register.
module i2s_capture_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 8,
  parameter int WAKE_W   = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [WAKE_W-1:0]   cfg_wake,
  input  logic                start,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                mic_valid,
  output logic                mic_en,
  output logic [DIV_W-1:0]    mic_div,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                overrun,
  output logic                busy,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    sample_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAKE = 2'd1, RUN = 2'd2, DRAIN = 2'd3} st_t;

  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(49);
  localparam logic [WAKE_W-1:0] WAKE_ONE = WAKE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  st_t               st;
  logic [WAKE_W-1:0] wake_cnt;
  logic [WAKE_W-1:0] wake_lat;
  logic              hs;

  assign hs    = m_valid & m_ready;
  assign busy  = (st != IDLE);
  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      mic_en     <= 1'b0;
      mic_div    <= DIV_RST;
      m_data     <= '0;
      m_valid    <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
      wake_cnt   <= '0;
      wake_lat   <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (start && !stop) begin
            mic_div    <= cfg_div;
            wake_lat   <= cfg_wake;
            overrun    <= 1'b0;
            sample_cnt <= '0;
            wake_cnt   <= '0;
            mic_en     <= 1'b1;
            st         <= (cfg_wake == '0) ? RUN : WAKE;
          end
        end
        WAKE: begin
          // stop has priority over reaching the discard terminal count
          if (stop) begin
            mic_en <= 1'b0;
            st     <= IDLE;
          end else if (mic_valid) begin
            wake_cnt <= wake_cnt + WAKE_ONE;
            if (wake_cnt == wake_lat - WAKE_ONE) st <= RUN;
          end
        end
        RUN: begin
          if (hs) sample_cnt <= sample_cnt + CNT_ONE;
          if (mic_valid && (!m_valid || m_ready)) begin
            m_data  <= mic_sample;
            m_valid <= 1'b1;
          end else if (mic_valid) begin
            overrun <= 1'b1;
          end else if (hs) begin
            m_valid <= 1'b0;
          end
          if (stop) begin
            mic_en <= 1'b0;
            st     <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) begin
            m_valid    <= 1'b0;
            sample_cnt <= sample_cnt + CNT_ONE;
            st         <= IDLE;
          end else if (!m_valid) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl; emitted samples are checked against a queue of expected data.
module tb_i2s_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_div;
  logic [15:0] cfg_wake;
  logic        start, stop;
  logic [15:0] mic_sample;
  logic        mic_valid;
  logic        mic_en;
  logic [7:0]  mic_div;
  logic [15:0] m_data;
  logic        m_valid, m_ready;
  logic        overrun, busy;
  logic [1:0]  state;
  logic [31:0] sample_cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [15:0] exp_q[$];

  i2s_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_wake(cfg_wake),
    .start(start), .stop(stop), .mic_sample(mic_sample), .mic_valid(mic_valid),
    .mic_en(mic_en), .mic_div(mic_div), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .overrun(overrun), .busy(busy), .state(state),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    mic_sample = s;
    mic_valid  = 1'b1;
    tick();
    mic_valid  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] d, input logic [15:0] w);
    cfg_div  = d;
    cfg_wake = w;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_mic_en"}, 32'(mic_en), 32'd0);
    chk({tag, "_mic_div"}, 32'(mic_div), 32'd49);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_cnt"}, sample_cnt, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard: every downstream handshake must match the oldest expected sample
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(m_data), 32'hdead_beef);
      end else begin
        chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; cfg_div = 8'd0; cfg_wake = 16'd0; start = 1'b0; stop = 1'b0;
    mic_sample = 16'd0; mic_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // 1: wake discard of 4, then two samples forwarded
    m_ready = 1'b1;
    pulse_start(8'd49, 16'd4);
    chk("t1_state_wake", 32'(state), 32'd1);
    chk("t1_mic_en", 32'(mic_en), 32'd1);
    chk("t1_mic_div", 32'(mic_div), 32'd49);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0006);
    for (int i = 1; i <= 6; i++) begin
      send(16'(i));
      if (i <= 3) chk("t1_wake_mvalid", 32'(m_valid), 32'd0);
    end
    tick(); tick();
    chk("t1_state_run", 32'(state), 32'd2);
    chk("t1_cnt", sample_cnt, 32'd2);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t1_drain", 32'(state), 32'd3);
    tick();
    chk("t1_idle", 32'(state), 32'd0);
    chk("t1_div_hold", 32'(mic_div), 32'd49);

    // 2: zero wake goes straight to RUN, latency 1
    m_ready = 1'b0;
    pulse_start(8'd7, 16'd0);
    chk("t2_state_run", 32'(state), 32'd2);
    chk("t2_mic_div", 32'(mic_div), 32'd7);
    chk("t2_cnt_clr", sample_cnt, 32'd0);
    exp_q.push_back(16'h1234);
    send(16'h1234);
    chk("t2_mvalid", 32'(m_valid), 32'd1);
    chk("t2_mdata", 32'(m_data), 32'h1234);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t2_mvalid_clr", 32'(m_valid), 32'd0);
    chk("t2_cnt", sample_cnt, 32'd1);

    // 3: backpressure drops the second sample and sets overrun
    exp_q.push_back(16'hAAAA);
    send(16'hAAAA);
    send(16'hBBBB);
    chk("t3_mdata_hold", 32'(m_data), 32'hAAAA);
    chk("t3_mvalid", 32'(m_valid), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd1);

    // 4: stop while stalled drains the held sample
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t4_drain", 32'(state), 32'd3);
    chk("t4_mic_en", 32'(mic_en), 32'd0);
    send(16'hCCCC);
    tick();
    chk("t4_drain_hold", 32'(state), 32'd3);
    chk("t4_mdata_hold", 32'(m_data), 32'hAAAA);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t4_idle", 32'(state), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_mvalid", 32'(m_valid), 32'd0);
    chk("t4_cnt", sample_cnt, 32'd2);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    pulse_start(8'd49, 16'd2);
    chk("t3_overrun_clr", 32'(overrun), 32'd0);
    chk("t4_wake", 32'(state), 32'd1);

    // 5: stop beats the terminal wake sample; start&stop in IDLE does nothing
    send(16'h0101);
    chk("t5_still_wake", 32'(state), 32'd1);
    stop = 1'b1;
    send(16'h0102);
    stop = 1'b0;
    chk("t5_stop_wins", 32'(state), 32'd0);
    chk("t5_mic_en", 32'(mic_en), 32'd0);
    start = 1'b1; stop = 1'b1; cfg_wake = 16'd0; tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_startstop", 32'(state), 32'd0);
    chk("t5_startstop_en", 32'(mic_en), 32'd0);

    // 6: reset mid-RUN with a held sample
    pulse_start(8'd3, 16'd0);
    send(16'h5555);
    chk("t6_mvalid", 32'(m_valid), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_reset("t6");

    tick();
    chk("end_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
